// File: rtl/alu_pipe_if.sv
// Handshake bus for alu_pipe: operand channel (in_*) and result channel (out_*).
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             carry_out;
  logic             zero;
  logic             negative;
  logic             overflow;

  // The block itself.
  modport slave (
    input  in_valid, a, b, alu_sel, out_ready,
    output in_ready, out_valid, alu_out, carry_out, zero, negative, overflow
  );

  // The producer/consumer driving the block.
  modport master (
    output in_valid, a, b, alu_sel, out_ready,
    input  in_ready, out_valid, alu_out, carry_out, zero, negative, overflow
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU with valid/ready on both sides.
// Single-cycle ops land in the output register at the accept edge; multiply
// runs a WIDTH-step shift-add sequence and lands WIDTH edges after accept.
module alu_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_SHL  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_ROTL = 4'd5;
  localparam logic [3:0] OP_ROTR = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd10;
  localparam logic [3:0] OP_NAND = 4'd11;
  localparam logic [3:0] OP_XNOR = 4'd12;
  localparam logic [3:0] OP_UGT  = 4'd13;
  localparam logic [3:0] OP_EQ   = 4'd14;
  localparam logic [3:0] OP_PASS = 4'd15;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q;
  logic               rdy_q;       // low in reset and for the first clock after it
  logic               out_valid_q;
  logic [WIDTH-1:0]   res_q;
  logic               cy_q, z_q, n_q, ov_q;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;

  logic               accept;
  logic [SHW-1:0]     sh_amt;
  logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w;
  logic [WIDTH-1:0]   res_c;
  logic               cy_c, ov_c;

  assign bus.in_ready  = rdy_q & (state_q == S_IDLE) & (~out_valid_q | bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_out   = res_q;
  assign bus.carry_out = cy_q;
  assign bus.zero      = z_q;
  assign bus.negative  = n_q;
  assign bus.overflow  = ov_q;

  assign sh_amt = bus.b[SHW-1:0];
  // Next partial product: add the shifted multiplicand when the current multiplier bit is set.
  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle datapath on the live operands; all arithmetic is one bit wider
  // so carry/borrow/shifted-out bits fall out of the top (or bottom) bit.
  always_comb begin
    add_w = {1'b0, bus.a} + {1'b0, bus.b};
    sub_w = {1'b0, bus.a} - {1'b0, bus.b};
    shl_w = {1'b0, bus.a} << sh_amt;
    shr_w = {bus.a, 1'b0} >> sh_amt;
    res_c = '0;
    cy_c  = 1'b0;
    ov_c  = 1'b0;
    unique case (bus.alu_sel)
      OP_ADD: begin
        res_c = add_w[WIDTH-1:0];
        cy_c  = add_w[WIDTH];
        ov_c  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (add_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = sub_w[WIDTH-1:0];
        cy_c  = sub_w[WIDTH];
        ov_c  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_MUL:  res_c = '0;  // handled by the shift-add sequence
      OP_SHL: begin
        res_c = shl_w[WIDTH-1:0];
        cy_c  = shl_w[WIDTH];
      end
      OP_SHR: begin
        res_c = shr_w[WIDTH:1];
        cy_c  = shr_w[0];
      end
      OP_ROTL: begin
        // Last bit out of the MSB wraps to bit 0.
        res_c = (bus.a << sh_amt) | (bus.a >> (WIDTH - int'(sh_amt)));
        cy_c  = (sh_amt != '0) & res_c[0];
      end
      OP_ROTR: begin
        // Last bit out of the LSB wraps to the MSB.
        res_c = (bus.a >> sh_amt) | (bus.a << (WIDTH - int'(sh_amt)));
        cy_c  = (sh_amt != '0) & res_c[WIDTH-1];
      end
      OP_AND:  res_c = bus.a & bus.b;
      OP_OR:   res_c = bus.a | bus.b;
      OP_XOR:  res_c = bus.a ^ bus.b;
      OP_NOR:  res_c = ~(bus.a | bus.b);
      OP_NAND: res_c = ~(bus.a & bus.b);
      OP_XNOR: res_c = ~(bus.a ^ bus.b);
      OP_UGT:  res_c = {{(WIDTH-1){1'b0}}, (bus.a > bus.b)};
      OP_EQ:   res_c = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
      OP_PASS: res_c = bus.a;
      default: res_c = '0;
    endcase
  end

  // Control FSM, multiply sequencer and registered result/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      cy_q        <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      ov_q        <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
    end else begin
      rdy_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (bus.alu_sel == OP_MUL) begin
              state_q     <= S_MUL;
              cnt_q       <= '0;
              acc_q       <= '0;
              mcand_q     <= {{WIDTH{1'b0}}, bus.a};
              mplier_q    <= bus.b;
              out_valid_q <= 1'b0;
            end else begin
              res_q       <= res_c;
              cy_q        <= cy_c;
              z_q         <= (res_c == '0);
              n_q         <= res_c[WIDTH-1];
              ov_q        <= ov_c;
              out_valid_q <= 1'b1;
            end
          end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH-1)) begin
            res_q       <= acc_d[WIDTH-1:0];
            cy_q        <= |acc_d[2*WIDTH-1:WIDTH];
            z_q         <= (acc_d[WIDTH-1:0] == '0);
            n_q         <= acc_d[WIDTH-1];
            ov_q        <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes model results, monitor pops on
// every output handshake. Directed cases first, then random traffic.
module tb_alu_pipe;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic c, z, n, v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  bit   rnd_done = 0;

  alu_pipe_if #(.WIDTH(W)) bus();
  alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic straight from the operation table.
  function automatic exp_t model(input longint a, input longint b, input int op);
    longint m, hi, lo, sa, sb, r;
    int     n;
    bit     c, v;
    exp_t   e;
    m  = (longint'(1) << W) - 1;
    hi = (longint'(1) << (W-1)) - 1;
    lo = -(longint'(1) << (W-1));
    sa = (a > hi) ? a - (m + 1) : a;
    sb = (b > hi) ? b - (m + 1) : b;
    n  = int'(b % W);
    r  = 0; c = 0; v = 0;
    case (op)
      0:  begin r = a + b; c = (r > m); v = (sa + sb > hi) || (sa + sb < lo); end
      1:  begin r = a - b; c = (a < b); v = (sa - sb > hi) || (sa - sb < lo); end
      2:  begin r = a * b; c = ((r >> W) != 0); end
      3:  begin r = a << n; c = (n != 0) && (((a >> (W-n)) & 1) != 0); end
      4:  begin r = a >> n; c = (n != 0) && (((a >> (n-1)) & 1) != 0); end
      5:  begin r = (a << n) | (a >> (W-n)); c = (n != 0) && (((a >> (W-n)) & 1) != 0); end
      6:  begin r = (a >> n) | (a << (W-n)); c = (n != 0) && (((a >> (n-1)) & 1) != 0); end
      7:  r = a & b;
      8:  r = a | b;
      9:  r = a ^ b;
      10: r = ~(a | b);
      11: r = ~(a & b);
      12: r = ~(a ^ b);
      13: r = (a > b) ? 1 : 0;
      14: r = (a == b) ? 1 : 0;
      default: r = a;
    endcase
    r = r & m;
    e.res = r[W-1:0];
    e.c = c;
    e.z = (r == 0);
    e.n = ((r >> (W-1)) & 1) != 0;
    e.v = v;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Present an operand set and hold it until the DUT takes it.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [3:0] op, output int waits);
    bus.in_valid = 1'b1; bus.a = ia; bus.b = ib; bus.alu_sel = op;
    waits = 0;
    do begin @(negedge clk); waits++; end while (!bus.in_ready && waits < 200);
    if (!bus.in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout: op %0d never accepted within 200 cycles", op);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(longint'(ia), longint'(ib), int'(op)));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Let every pending result drain out.
  task automatic drain();
    int k;
    bus.out_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && k < 100) begin @(negedge clk); k++; end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: compare on each output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got res 0x%0h with empty scoreboard", bus.alu_out);
        end else begin
          e = exp_q.pop_front();
          if ({bus.alu_out, bus.carry_out, bus.zero, bus.negative, bus.overflow} !== e) begin
            n_fail++;
            $display("FAIL result: got res=0x%0h c%0b z%0b n%0b v%0b expected res=0x%0h c%0b z%0b n%0b v%0b",
                     bus.alu_out, bus.carry_out, bus.zero, bus.negative, bus.overflow,
                     e.res, e.c, e.z, e.n, e.v);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, k, bad;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.alu_sel = '0; bus.out_ready = 1'b1;
    #2;
    chk("reset_outputs", {bus.out_valid, bus.in_ready, bus.alu_out, bus.carry_out,
                          bus.zero, bus.negative, bus.overflow}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rdy_low_before_first_clk", bus.in_ready, 1'b0);
    @(posedge clk); #1;

    // add with carry-out and zero; latency one edge
    issue(8'hFF, 8'h01, 4'd0, w);
    @(negedge clk);
    chk("add_ff_01", {bus.out_valid, bus.alu_out, bus.carry_out, bus.zero, bus.overflow},
        {1'b1, 8'h00, 1'b1, 1'b1, 1'b0});
    @(posedge clk); #1;
    issue(8'h7F, 8'h01, 4'd0, w);
    @(negedge clk);
    chk("add_ovf", {bus.alu_out, bus.negative, bus.overflow, bus.carry_out}, {8'h80, 1'b1, 1'b1, 1'b0});
    @(posedge clk); #1;
    issue(8'h10, 8'h20, 4'd1, w);
    @(negedge clk);
    chk("sub_borrow", {bus.alu_out, bus.carry_out, bus.negative}, {8'hF0, 1'b1, 1'b1});
    drain();

    // multiply latency and in_ready blackout
    issue(8'h10, 8'h11, 4'd2, w);
    k = 0; bad = 0;
    while (k < 40) begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (bus.in_ready) bad++;
      k++;
    end
    chk("mul_latency", 64'(k), 64'(W));
    chk("mul_in_ready_low", 64'(bad), 64'd0);
    chk("mul_10x11", {bus.alu_out, bus.carry_out}, {8'h10, 1'b1});
    drain();
    issue(8'h0F, 8'h03, 4'd2, w);
    drain();

    // shifts and rotates
    issue(8'h81, 8'h01, 4'd3, w);
    @(negedge clk);
    chk("shl", {bus.alu_out, bus.carry_out}, {8'h02, 1'b1});
    @(posedge clk); #1;
    issue(8'h01, 8'h03, 4'd6, w);
    @(negedge clk);
    chk("rotr", {bus.alu_out, bus.carry_out}, {8'h20, 1'b0});
    @(posedge clk); #1;
    issue(8'h80, 8'h00, 4'd4, w);
    @(negedge clk);
    chk("shr_zero_amt", {bus.alu_out, bus.carry_out}, {8'h80, 1'b0});
    drain();

    // back-to-back stream at full rate
    issue(8'hAA, 8'h55, 4'd9, w);  chk("stream_rdy0", 64'(w), 64'd1);
    issue(8'hF0, 8'h3C, 4'd7, w);  chk("stream_rdy1", 64'(w), 64'd1);
    issue(8'h33, 8'h33, 4'd14, w); chk("stream_rdy2", 64'(w), 64'd1);
    drain();

    // same stream with the consumer stalled for 3 cycles
    bus.out_ready = 1'b0;
    issue(8'hAA, 8'h55, 4'd9, w);
    bus.in_valid = 1'b1; bus.a = 8'hF0; bus.b = 8'h3C; bus.alu_sel = 4'd7;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (!bus.out_valid || bus.alu_out !== 8'hFF || bus.in_ready) bad++;
    end
    chk("hold_stall", 64'(bad), 64'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    issue(8'hF0, 8'h3C, 4'd7, w);
    issue(8'h33, 8'h33, 4'd14, w);
    drain();

    // reset in the middle of a multiply
    issue(8'h5A, 8'h3C, 4'd2, w);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_mul", {bus.out_valid, bus.in_ready, bus.alu_out, bus.carry_out,
                        bus.zero, bus.negative, bus.overflow}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_state", {bus.out_valid, bus.in_ready}, 2'b00);
    @(posedge clk); #1;
    issue(8'h02, 8'h03, 4'd0, w);
    @(negedge clk);
    chk("post_rst_add", {bus.out_valid, bus.alu_out}, {1'b1, 8'h05});
    drain();

    // random traffic with a randomly stalling consumer
    fork
      begin
        for (int i = 0; i < 300; i++)
          issue(W'($urandom), W'($urandom), 4'($urandom_range(0, 15)), w);
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
